// File: rtl/signed_divide_by_power_of_2_pipelined_pkg.sv
// Shared defaults and helpers for the signed power-of-two divider.
// nz_below reports whether any bit under position k is set, i.e. whether the shift discards a non-zero remainder.
package sdiv_pow2_pkg;

  localparam int N_DEF   = 8;
  localparam int SW_DEF  = $clog2(N_DEF);
  localparam int NZ_MAXW = 64;

  function automatic logic nz_below(input logic [NZ_MAXW-1:0] data, input logic [31:0] k);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < NZ_MAXW; i++) begin
      if (32'(i) < k) acc = acc | data[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/signed_divide_by_power_of_2_pipelined_arsh.sv
// Combinational arithmetic right shift by a run-time amount.
// Built as a log2 barrel: stage s shifts by 2**s when k[s] is set, filling with the sign bit.
module arithmetic_right_shift_variable #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] k,
  output logic [N-1:0]  res
);

  logic [N-1:0] w_stage [SW+1];

  assign w_stage[0] = a;

  for (genvar s = 0; s < SW; s++) begin : g_stage
    localparam int SH = 1 << s;
    // The sign of a survives every stage, so the fill can always come from a[N-1].
    assign w_stage[s+1] = k[s] ? {{SH{a[N-1]}}, w_stage[s][N-1:SH]} : w_stage[s];
  end

  assign res = w_stage[SW];

endmodule

// File: rtl/signed_divide_by_power_of_2_pipelined.sv
// Two-stage valid/ready pipeline computing a signed divide by 2**shift, rounded toward zero.
// Stage 1 shifts and records the correction inputs; stage 2 adds +1 when a negative dividend lost non-zero bits.
module signed_divide_by_power_of_2_pipelined
  import sdiv_pow2_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shift,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);

  // Handshake: a transfer happens on any cycle where valid and ready are both high.
  // A stage that holds valid while its consumer is not ready keeps its data and valid unchanged.

  logic                w_adv1;
  logic                w_adv2;
  logic [N-1:0]        w_q;
  logic                w_nz;
  logic                w_corr;
  logic [NZ_MAXW-1:0]  w_data_ext;
  logic [31:0]         w_shift_ext;

  logic                r_v1;
  logic [N-1:0]        r_q1;
  logic                r_neg1;
  logic                r_nz1;
  logic                r_v2;
  logic [N-1:0]        r_d2;

  assign w_adv2   = ~r_v2 | down_ready;
  assign w_adv1   = ~r_v1 | w_adv2;
  assign up_ready = w_adv1;

  arithmetic_right_shift_variable #(
    .N  (N),
    .SW (SW)
  ) u_arsh (
    .a   (up_data),
    .k   (up_shift),
    .res (w_q)
  );

  assign w_data_ext  = NZ_MAXW'(up_data);
  assign w_shift_ext = 32'(up_shift);
  assign w_nz        = nz_below(w_data_ext, w_shift_ext);

  // neg1 & nz1 implies q1 < 0, so the +1 can never wrap past zero.
  assign w_corr = r_neg1 & r_nz1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_q1   <= '0;
      r_neg1 <= 1'b0;
      r_nz1  <= 1'b0;
    end else if (w_adv1) begin
      r_v1   <= up_valid;
      r_q1   <= w_q;
      r_neg1 <= up_data[N-1];
      r_nz1  <= w_nz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_d2 <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      r_d2 <= r_q1 + {{(N-1){1'b0}}, w_corr};
    end
  end

  assign down_valid = r_v2;
  assign down_data  = r_d2;

endmodule

// File: tb/tb_signed_divide_by_power_of_2_pipelined.sv
// Bench for the pipelined signed power-of-two divider: directed table, hand-written
// backpressure/streaming/reset sequences, and a randomised run against a queue of expected results.
`timescale 1ns/1ps
module tb_signed_divide_by_power_of_2_pipelined;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [N-1:0]  up_data = '0;
  logic [SW-1:0] up_shift = '0;
  logic          down_valid;
  logic          down_ready = 1'b1;
  logic [N-1:0]  down_data;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]  d;
    logic [SW-1:0] k;
    logic [N-1:0]  e;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  signed_divide_by_power_of_2_pipelined #(.N(N), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_shift   (up_shift),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [N-1:0] d, input logic [SW-1:0] k);
    int a;
    a = int'($signed(d));
    return N'(a / (1 << k));
  endfunction

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  // Driver: called just after a rising edge, returns just after the edge that took the item.
  task automatic send(input logic [N-1:0] d, input logic [SW-1:0] k, input logic [N-1:0] e);
    bit ok;
    ok = 1'b0;
    up_valid = 1'b1;
    up_data  = d;
    up_shift = k;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      if (up_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (ok) exp_q.push_back(e);
    else chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    up_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  logic         prev_stall = 1'b0;
  logic [N-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(down_valid), 32'd1);
        chk("hold_data", 32'(down_data), 32'(prev_data));
      end
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'(down_data), 32'hFFFF_FFFF);
        else chk("out_data", 32'(down_data), 32'(exp_q.pop_front()));
      end
      prev_stall = down_valid && !down_ready;
      prev_data  = down_data;
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    report();
    $finish;
  end

  bit rand_on;

  initial begin
    tbl[0]  = '{8'hF9, 3'd2, 8'hFF};  // -7  / 4   = -1
    tbl[1]  = '{8'h07, 3'd2, 8'h01};  //  7  / 4   =  1
    tbl[2]  = '{8'hF8, 3'd2, 8'hFE};  // -8  / 4   = -2
    tbl[3]  = '{8'h80, 3'd7, 8'hFF};  // -128/ 128 = -1
    tbl[4]  = '{8'h80, 3'd0, 8'h80};  // -128/ 1   = -128
    tbl[5]  = '{8'h7F, 3'd7, 8'h00};  //  127/ 128 =  0
    tbl[6]  = '{8'hFF, 3'd3, 8'h00};  // -1  / 8   =  0
    tbl[7]  = '{8'h64, 3'd3, 8'h0C};  //  100/ 8   =  12
    tbl[8]  = '{8'h9C, 3'd3, 8'hF4};  // -100/ 8   = -12
    tbl[9]  = '{8'hF7, 3'd1, 8'hFC};  // -9  / 2   = -4
    tbl[10] = '{8'h00, 3'd5, 8'h00};  //  0  / 32  =  0
    tbl[11] = '{8'h81, 3'd6, 8'hFF};  // -127/ 64  = -1
    tbl[12] = '{8'h40, 3'd6, 8'h01};  //  64 / 64  =  1
    tbl[13] = '{8'hBF, 3'd6, 8'hFF};  // -65 / 64  = -1

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_down_valid", 32'(down_valid), 32'd0);
    chk("rst_down_data", 32'(down_data), 32'd0);
    chk("rst_up_ready", 32'(up_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      send(tbl[i].d, tbl[i].k, tbl[i].e);
      @(negedge clk);
      chk("lat_not_early", 32'(down_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid", 32'(down_valid), 32'd1);
      chk("tbl_data", 32'(down_data), 32'(tbl[i].e));
      drain("tbl_drain");
    end

    // Backpressure: only two items fit while the consumer is stalled.
    down_ready = 1'b0;
    fork
      begin
        send(8'hF9, 3'd2, 8'hFF);
        send(8'h07, 3'd2, 8'h01);
        send(8'hF8, 3'd2, 8'hFE);
        send(8'h64, 3'd2, 8'h19);
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_up_ready", 32'(up_ready), 32'd0);
        chk("bp_accepted", 32'(exp_q.size()), 32'd2);
        chk("bp_down_valid", 32'(down_valid), 32'd1);
        chk("bp_head", 32'(down_data), 32'hFF);
        @(posedge clk);
        #1;
        down_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Streaming: 16 back-to-back items must come out with no gaps.
    fork
      begin
        for (int j = 0; j < 16; j++) begin
          logic [N-1:0] d;
          d = N'(j * 29 - 100);
          send(d, SW'(j % 8), model(d, SW'(j % 8)));
        end
      end
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!down_valid && t < 20) begin
          @(negedge clk);
          t++;
        end
        chk("stream_start", 32'(down_valid), 32'd1);
        repeat (15) begin
          @(negedge clk);
          chk("stream_gap", 32'(down_valid), 32'd1);
        end
      end
    join
    drain("stream_drain");

    // Alternating consumer ready while streaming.
    fork
      begin
        for (int j = 0; j < 16; j++) begin
          logic [N-1:0] d;
          d = N'(200 - j * 23);
          send(d, SW'((j * 3) % 8), model(d, SW'((j * 3) % 8)));
        end
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          down_ready = ~down_ready;
        end
        down_ready = 1'b1;
      end
    join
    down_ready = 1'b1;
    drain("toggle_drain");

    // Reset with two items in flight.
    down_ready = 1'b0;
    send(8'hF9, 3'd2, 8'hFF);
    send(8'h07, 3'd2, 8'h01);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    down_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_down_valid", 32'(down_valid), 32'd0);
    chk("mid_rst_up_ready", 32'(up_ready), 32'd1);
    @(posedge clk);
    #1;
    send(8'h9C, 3'd3, 8'hF4);
    drain("post_rst_drain");
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(down_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Random run with random consumer stalls.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [N-1:0]  d;
          logic [SW-1:0] k;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          d = N'($urandom_range(0, 255));
          k = SW'($urandom_range(0, 7));
          send(d, k, model(d, k));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          down_ready = ($urandom_range(0, 3) != 0);
        end
        down_ready = 1'b1;
      end
    join
    down_ready = 1'b1;
    drain("rand_drain");

    report();
    $finish;
  end

endmodule
